// File: rtl/data_bus_arbiter_pkg.sv
// Shared types for the two-master data bus arbiter: master index, master count
// and the registered response record.
package miriscv_arb_pkg;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_master_e;

    localparam int ARB_NUM_MASTERS = 2;

    typedef struct packed {
        logic        valid;
        arb_master_e owner;
        logic        err;
    } arb_resp_t;

endpackage

// File: rtl/data_bus_arbiter_pick2.sv
// Two-way combinational priority pick. Define ARB_ROUND_ROBIN_EN to break ties
// away from the last granted master; otherwise master 0 always wins a tie.
import miriscv_arb_pkg::*;

module arb_pick2 (
    input  logic [ARB_NUM_MASTERS-1:0] req,
    input  arb_master_e                last,
    output logic [ARB_NUM_MASTERS-1:0] gnt,
    output arb_master_e                idx
);

`ifndef ARB_ROUND_ROBIN_EN
    // The pointer only matters for round-robin; it is deliberately left unused here.
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        gnt = '0;
        idx = ARB_M0;
        unique case (req)
            2'b01: begin
                gnt = 2'b01;
                idx = ARB_M0;
            end
            2'b10: begin
                gnt = 2'b10;
                idx = ARB_M1;
            end
            2'b11: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last == ARB_M0) begin
                    gnt = 2'b10;
                    idx = ARB_M1;
                end else begin
                    gnt = 2'b01;
                    idx = ARB_M0;
                end
`else
                gnt = 2'b01;
                idx = ARB_M0;
`endif
            end
            default: begin
                gnt = '0;
                idx = ARB_M0;
            end
        endcase
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the RAM data port between two masters with a fixed one-cycle response;
// out-of-range accesses are answered locally. Tie policy set by ARB_ROUND_ROBIN_EN.
import miriscv_arb_pkg::*;

module data_bus_arbiter #(
    parameter int RAM_SIZE = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic [31:0] s_rdata_i
);

    localparam logic [31:0] RAM_LIMIT = 32'(RAM_SIZE);

    logic [ARB_NUM_MASTERS-1:0] req_vec;
    logic [ARB_NUM_MASTERS-1:0] gnt_vec;
    arb_master_e                gnt_idx;
    arb_master_e                last_q;
    arb_resp_t                  resp_q;

    logic        any_gnt;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        in_range;
    logic        resp_live;

    // Requests are masked during reset so nothing is granted while rst_i is high.
    assign req_vec = rst_i ? '0 : {m1_req_i, m0_req_i};

    arb_pick2 u_pick (
        .req  (req_vec),
        .last (last_q),
        .gnt  (gnt_vec),
        .idx  (gnt_idx)
    );

    assign any_gnt  = |gnt_vec;
    assign m0_gnt_o = gnt_vec[0];
    assign m1_gnt_o = gnt_vec[1];

    always_comb begin
        sel_we    = m0_we_i;
        sel_be    = m0_be_i;
        sel_addr  = m0_addr_i;
        sel_wdata = m0_wdata_i;
        if (gnt_idx == ARB_M1) begin
            sel_we    = m1_we_i;
            sel_be    = m1_be_i;
            sel_addr  = m1_addr_i;
            sel_wdata = m1_wdata_i;
        end
    end

    assign in_range = (sel_addr < RAM_LIMIT);

    // The slave side is zeroed when idle; out-of-range grants never raise s_req_o.
    always_comb begin
        s_req_o   = 1'b0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        if (any_gnt) begin
            s_req_o   = in_range;
            s_we_o    = sel_we;
            s_be_o    = sel_be;
            s_addr_o  = sel_addr;
            s_wdata_o = sel_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q <= '{valid: 1'b0, owner: ARB_M0, err: 1'b0};
            last_q <= ARB_M1;
        end else begin
            resp_q.valid <= any_gnt;
            if (any_gnt) begin
                resp_q.owner <= gnt_idx;
                resp_q.err   <= ~in_range;
                last_q       <= gnt_idx;
            end
        end
    end

    // A response still in flight when reset rises is suppressed rather than delivered.
    assign resp_live = resp_q.valid & ~rst_i;

    always_comb begin
        m0_rvalid_o = resp_live & (resp_q.owner == ARB_M0);
        m1_rvalid_o = resp_live & (resp_q.owner == ARB_M1);
        m0_err_o    = m0_rvalid_o & resp_q.err;
        m1_err_o    = m1_rvalid_o & resp_q.err;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        if (m0_rvalid_o && !resp_q.err) begin
            m0_rdata_o = s_rdata_i;
        end
        if (m1_rvalid_o && !resp_q.err) begin
            m1_rdata_o = s_rdata_i;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with a small byte-enabled RAM model;
// tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_data_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [3:0]  m0_be = '0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;

    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [3:0]  m1_be = '0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;

    logic        s_req, s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata = '0;

    logic [31:0] mem [0:63];

    int vec_count  = 0;
    int miss_count = 0;

    always #5 clk = ~clk;

    data_bus_arbiter #(.RAM_SIZE(256)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .m0_req_i    (m0_req),
        .m0_we_i     (m0_we),
        .m0_be_i     (m0_be),
        .m0_addr_i   (m0_addr),
        .m0_wdata_i  (m0_wdata),
        .m0_gnt_o    (m0_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m0_err_o    (m0_err),
        .m1_req_i    (m1_req),
        .m1_we_i     (m1_we),
        .m1_be_i     (m1_be),
        .m1_addr_i   (m1_addr),
        .m1_wdata_i  (m1_wdata),
        .m1_gnt_o    (m1_gnt),
        .m1_rvalid_o (m1_rvalid),
        .m1_rdata_o  (m1_rdata),
        .m1_err_o    (m1_err),
        .s_req_o     (s_req),
        .s_we_o      (s_we),
        .s_be_o      (s_be),
        .s_addr_o    (s_addr),
        .s_wdata_o   (s_wdata),
        .s_rdata_i   (s_rdata)
    );

    // RAM stand-in: read data appears the cycle after s_req; word 4 preloaded on reset.
    always @(posedge clk) begin
        if (rst) begin
            mem[4] <= 32'hDEADBEEF;
        end else if (s_req) begin
            if (s_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_be[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
                end
            end else begin
                s_rdata <= mem[s_addr[7:2]];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int m, input logic req, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] exp_m0_seq;
    logic [5:0] exp_m1_seq;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_m0_seq = 6'b010101;
        exp_m1_seq = 6'b101010;
`else
        exp_m0_seq = 6'b111111;
        exp_m1_seq = 6'b000000;
`endif
        // Reset with a request pending: nothing may be granted or reported.
        nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        #1;
        checkOutput("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        checkOutput("rst_s_req", 32'(s_req), 32'd0);
        checkOutput("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        checkOutput("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        checkOutput("rst_s_addr", s_addr, 32'd0);

        // Continuous contention for six cycles right after reset.
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            checkOutput($sformatf("tie%0d_m0_gnt", i), 32'(m0_gnt), 32'(exp_m0_seq[i]));
            checkOutput($sformatf("tie%0d_m1_gnt", i), 32'(m1_gnt), 32'(exp_m1_seq[i]));
            nextCycle();
        end
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        nextCycle();

        // Single master read of the preloaded word.
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        #1;
        checkOutput("rd_m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("rd_m1_gnt", 32'(m1_gnt), 32'd0);
        checkOutput("rd_s_req", 32'(s_req), 32'd1);
        checkOutput("rd_s_addr", s_addr, 32'h10);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
        checkOutput("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        checkOutput("rd_m0_err", 32'(m0_err), 32'd0);
        checkOutput("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
        checkOutput("rd_m1_rdata", m1_rdata, 32'd0);
        nextCycle();

        // Back-to-back: m1 writes, m0 reads the same word on the next cycle.
        applyStimulus(1, 1'b1, 1'b1, 4'hF, 32'h20, 32'h12345678);
        #1;
        checkOutput("wr_m1_gnt", 32'(m1_gnt), 32'd1);
        checkOutput("wr_s_we", 32'(s_we), 32'd1);
        checkOutput("wr_s_wdata", s_wdata, 32'h12345678);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        #1;
        checkOutput("b2b_m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("b2b_m1_rvalid", 32'(m1_rvalid), 32'd1);
        checkOutput("b2b_m1_err", 32'(m1_err), 32'd0);
        checkOutput("b2b_m0_rvalid", 32'(m0_rvalid), 32'd0);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("b2b_m0_rvalid2", 32'(m0_rvalid), 32'd1);
        checkOutput("b2b_m0_rdata", m0_rdata, 32'h12345678);
        nextCycle();

        // Out-of-range read, followed by an in-range m1 read.
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        #1;
        checkOutput("oor_m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("oor_s_req", 32'(s_req), 32'd0);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        #1;
        checkOutput("oor_m0_rvalid", 32'(m0_rvalid), 32'd1);
        checkOutput("oor_m0_err", 32'(m0_err), 32'd1);
        checkOutput("oor_m0_rdata", m0_rdata, 32'd0);
        checkOutput("oor_m1_gnt", 32'(m1_gnt), 32'd1);
        checkOutput("oor_s_req2", 32'(s_req), 32'd1);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("oor_m1_rvalid", 32'(m1_rvalid), 32'd1);
        checkOutput("oor_m1_err", 32'(m1_err), 32'd0);
        checkOutput("oor_m1_rdata", m1_rdata, 32'hDEADBEEF);
        checkOutput("oor_m0_rvalid2", 32'(m0_rvalid), 32'd0);
        nextCycle();

        // Partial byte-enable write passes through unchanged.
        applyStimulus(1, 1'b1, 1'b1, 4'h3, 32'h24, 32'hAABBCCDD);
        #1;
        checkOutput("be_s_be", 32'(s_be), 32'h3);
        checkOutput("be_s_we", 32'(s_we), 32'd1);
        checkOutput("be_s_addr", s_addr, 32'h24);
        nextCycle();
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("be_m1_rvalid", 32'(m1_rvalid), 32'd1);
        nextCycle();

        // Reset in the cycle after an m1 grant drops the pending response.
        applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        #1;
        checkOutput("mrst_m1_gnt", 32'(m1_gnt), 32'd1);
        nextCycle();
        rst = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
        #1;
        checkOutput("mrst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        checkOutput("mrst_m1_rdata", m1_rdata, 32'd0);
        checkOutput("mrst_m0_gnt", 32'(m0_gnt), 32'd0);
        checkOutput("mrst_m1_gnt2", 32'(m1_gnt), 32'd0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("post_m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("post_m1_gnt", 32'(m1_gnt), 32'd0);
        checkOutput("post_m1_rvalid", 32'(m1_rvalid), 32'd0);
        nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("post_m0_rvalid", 32'(m0_rvalid), 32'd1);
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter that shares the single data port of `miriscv_ram` between the core load/store unit (master 0) and a second data master such as a program loader or DMA (master 1). It sits between the masters and the RAM data port, ahead of the address decoder path. It accepts at most one transaction per cycle and returns a response exactly one cycle after acceptance. Addresses outside RAM are answered locally with an error response and are never forwarded.

## Interface
Parameters:
- `RAM_SIZE`, 256: RAM size in bytes. Addresses `>= RAM_SIZE` are out of range.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `m0_req_i`, `m1_req_i`  in  1  master request.
- `m0_we_i`, `m1_we_i`  in  1  1 = write, 0 = read.
- `m0_be_i`, `m1_be_i`  in  4  byte enables.
- `m0_addr_i`, `m1_addr_i`  in  32  byte address.
- `m0_wdata_i`, `m1_wdata_i`  in  32  write data.
- `m0_gnt_o`, `m1_gnt_o`  out  1  request accepted this cycle (combinational).
- `m0_rvalid_o`, `m1_rvalid_o`  out  1  response valid; one cycle after grant.
- `m0_rdata_o`, `m1_rdata_o`  out  32  read data; qualified by rvalid.
- `m0_err_o`, `m1_err_o`  out  1  out-of-range error; qualified by rvalid.
- `s_req_o`, `s_we_o`  out  1  to RAM data port.
- `s_be_o`  out  4  to RAM.
- `s_addr_o`, `s_wdata_o`  out  32  to RAM.
- `s_rdata_i`  in  32  RAM read data, valid one cycle after `s_req_o`.

## Operation
Selection:
- If exactly one master requests, that master is granted.
- If both request, the winner is chosen by the configured policy.
- Masters hold req/we/be/addr/wdata stable until granted.

Forwarding:
- The granted master's we, be, addr and wdata drive the `s_*` outputs.
- `s_req_o` = grant AND address in range (`addr < RAM_SIZE`).
- When nothing is granted, `s_*` outputs are 0.

Response state:
- Registered `resp_valid_q`, `resp_owner_q` (0/1) and `resp_err_q` capture each accepted transaction.
- `mX_rvalid_o` = `resp_valid_q` AND `resp_owner_q == X`.

Response data:
- Reads: `mX_rdata_o` = `s_rdata_i` when `resp_err_q` = 0; otherwise 0.
- Writes also receive rvalid; rdata is then don't-care.
- `mX_err_o` = `resp_err_q` while rvalid.
- Out-of-range transactions are granted normally, never touch the RAM, and respond with err = 1 and rdata = 0.

Pipelining and fairness:
- Back-to-back grants are allowed, so a response and a new grant can occur in the same cycle.
- No master may wait more than one competing grant under round-robin.

Last-grant pointer:
- `last_q` is updated to the granted index on every grant.
- It is held when there is no grant.

## Timing
- Grant in cycle N means `s_req_o` is asserted in cycle N and rvalid is asserted in cycle N+1. Latency is fixed at 1.
- Throughput: 1 transaction per cycle.
- Reset values: `resp_valid_q` = 0, `resp_owner_q` = 0, `resp_err_q` = 0, `last_q` = 1 (so master 0 wins the first tie).
- All outputs are 0 during and after reset, until a request arrives.
- Reset asserted in the cycle after a grant: the pending response is dropped, and no rvalid is issued.
- A request present during reset is not granted while `rst_i` = 1.
- Simultaneous requests in the same cycle a response returns: the response goes to `resp_owner_q`, and the new grant follows the policy independently.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on a tie, grant the master `!= last_q`.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority; master 0 always wins a tie. `last_q` is still maintained but unused.
- Latency, error handling and reset behaviour are identical in both modes.

## Structure
- Shared package `miriscv_arb_pkg`:
  - master index typedef (`arb_master_e`: `ARB_M0`, `ARB_M1`);
  - constant `ARB_NUM_MASTERS` = 2;
  - response struct (valid, owner, err).
- One sub-module, `arb_pick2`: combinational two-way priority pick.
  - Inputs: req[1:0], last.
  - Outputs: one-hot gnt[1:0] and the granted index.
  - It contains the `ARB_ROUND_ROBIN_EN` selection.
- The top holds the response registers, the `last_q` pointer, the address range check and the muxes.

## Test plan
- Single master read: m0 reads addr 0x10 with RAM word 0xDEADBEEF → `m0_gnt_o` = 1 in cycle N; `m0_rvalid_o` = 1 with `m0_rdata_o` = 0xDEADBEEF in N+1; m1 outputs stay 0.
- Contention with round-robin: both masters request continuously for 6 cycles → grants alternate m0, m1, m0, m1, m0, m1, starting with m0 after reset. Without the macro, all 6 grants go to m0.
- Back-to-back traffic: m1 writes 0x12345678 to 0x20 with be = 0xF, then m0 reads 0x20 the next cycle → m0 rdata = 0x12345678. The write rvalid lands on m1 in the same cycle that m0 is granted.
- Out of range: m0 reads 0x100 with `RAM_SIZE` = 256 → granted, `s_req_o` = 0, and in N+1 rvalid = 1, err = 1, rdata = 0. An in-range access by m1 in the next cycle is unaffected.
- Reset mid-operation: grant an m1 read, then assert `rst_i` in N+1 → no m1 rvalid. After release, a tie grants m0 first.
- Byte-enable pass-through: m1 writes with be = 0x3 → `s_be_o` = 0x3 and `s_we_o` = 1 in the grant cycle.
